// File: rtl/monster_direction_ctrl.sv
// Per-monster heading scheduler: collects blocked directions from collision probes over a
// frame, then holds or re-rolls the heading at the next frame start.
module monster_direction_ctrl #(
    parameter int unsigned HOLD_FRAMES = 32,
    parameter logic [1:0]  RESET_DIR   = 2'b00
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       bool_monsterRandomCollision,
    input  logic [1:0] monsterRandomCollisionReq,
    input  logic       wallDrawingRequest,
    input  logic [1:0] random_move,
    output logic [1:0] direction,
    output logic       moveEn,
    output logic [3:0] blockedMask,
    output logic       dirChanged,
    output logic       busy
);

    typedef enum logic [1:0] {
        COLLECT,
        DECIDE,
        SCAN
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

    state_t     state;
    logic [3:0] acc;
    logic [7:0] frame_cnt;
    logic [1:0] cand;
    logic [1:0] scan_idx;
    logic       hit;
    logic [3:0] hit_vec;

    assign hit     = bool_monsterRandomCollision && wallDrawingRequest;
    assign hit_vec = hit ? (4'b0001 << monsterRandomCollisionReq) : 4'b0000;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state       <= COLLECT;
            acc         <= 4'b0000;
            frame_cnt   <= 8'd0;
            cand        <= 2'b00;
            scan_idx    <= 2'b00;
            direction   <= RESET_DIR;
            moveEn      <= 1'b0;
            blockedMask <= 4'b0000;
            dirChanged  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            dirChanged <= 1'b0;
            // Hits seen while deciding already belong to the frame that just started.
            acc        <= acc | hit_vec;
            case (state)
                COLLECT: begin
                    if (startOfFrame) begin
                        blockedMask <= acc | hit_vec;
                        acc         <= 4'b0000;
                        state       <= DECIDE;
                        busy        <= 1'b1;
                    end
                end
                DECIDE: begin
                    if (!blockedMask[direction] && (frame_cnt < HOLD_LAST)) begin
                        frame_cnt <= frame_cnt + 8'd1;
                        moveEn    <= 1'b1;
                        state     <= COLLECT;
                        busy      <= 1'b0;
                    end else begin
                        cand     <= random_move;
                        scan_idx <= 2'b00;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (!blockedMask[cand]) begin
                        direction  <= cand;
                        moveEn     <= 1'b1;
                        frame_cnt  <= 8'd0;
                        dirChanged <= (cand != direction);
                        state      <= COLLECT;
                        busy       <= 1'b0;
                    end else if (scan_idx == 2'd3) begin
                        // Boxed in on all sides: keep heading, stand still this frame.
                        moveEn    <= 1'b0;
                        frame_cnt <= 8'd0;
                        state     <= COLLECT;
                        busy      <= 1'b0;
                    end else begin
                        cand     <= cand + 2'd1;
                        scan_idx <= scan_idx + 2'd1;
                    end
                end
                default: begin
                    state <= COLLECT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
